gpio_ctrl: RTL and testbench



---
 rtl/gpio_pkg.sv | 33 +++
 rtl/gpio_debounce.sv | 80 ++++++++
 rtl/gpio_ctrl.sv | 175 +++++++++++++++++
 tb/tb_gpio_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Shared definitions for the gpio_ctrl peripheral. These are the
//               register word indices, the bus data width and the edge-select
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  // Width of the CPU word bus.
  localparam int DATA_W = 32;

  // Register word indices, taken from addr[4:2].
  localparam logic [2:0] GPIO_OUT      = 3'd0;
  localparam logic [2:0] GPIO_IN       = 3'd1;
  localparam logic [2:0] GPIO_IRQ_EN   = 3'd2;
  localparam logic [2:0] GPIO_EDGE_SEL = 3'd3;
  localparam logic [2:0] GPIO_PEND     = 3'd4;

  // Per-bit edge polarity that raises a pending interrupt.
  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_sel_e;

  // True when a stable-state transition to new_level matches the selected edge.
  function automatic logic edge_match(input logic new_level, input edge_sel_e sel);
    return (sel == EDGE_RISE) ? new_level : ~new_level;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : gpio_debounce
// Description : Single-bit input conditioner. It uses a 2-flop synchroniser
//               followed by a stability-window debouncer. 'change' is a
//               combinational strobe. It means that 'stable' takes the
//               opposite level at the coming clock edge.
//               Build option GPIO_DEBOUNCE_EN: when it is defined, the
//               debounce counter is present. When it is undefined, the
//               synchronised level is used directly.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
`ifdef GPIO_DEBOUNCE_EN
  output logic settled,
`endif
  output logic stable,
  output logic change
);

  logic sync_q1;
  logic sync_q2;

  // Two-flop synchroniser that brings the asynchronous pin into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= pin;
      sync_q2 <= sync_q1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int               CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             stable_q;
  logic             differ;
  logic             at_max;

  assign differ = sync_q2 ^ stable_q;
  assign at_max = (cnt_q == CNT_MAX);

  // Count consecutive cycles of disagreement. The new level is accepted once
  // the window is full. Any agreement restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (!differ) begin
      cnt_q <= '0;
    end else if (at_max) begin
      stable_q <= sync_q2;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stable  = stable_q;
  assign change  = differ & at_max;
  assign settled = ~differ;
`else
  // Without debouncing, the window length has no meaning.
  localparam int unused_deb_cycles = DEB_CYCLES;

  assign stable = sync_q2;
  assign change = sync_q1 ^ sync_q2;
`endif

endmodule
`default_nettype wire

// File: rtl/gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_ctrl
// Description : Memory-mapped GPIO peripheral on an en/we word bus. It has
//               N_OUT output bits and N_IN conditioned input bits. Each input
//               bit has edge-detect interrupts, and all of them are merged
//               into a single level irq. The read path is registered.
//               Build option GPIO_DEBOUNCE_EN: when it is defined, it enables
//               per-bit debouncing with a window of DEB_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int N_OUT      = 8,
  parameter int N_IN       = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [4:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic [N_OUT-1:0]  gpio_out,
  input  logic [N_IN-1:0]   gpio_in,
  output logic              irq
);

  logic [N_OUT-1:0]  out_q;
  logic [N_IN-1:0]   irq_en_q;
  logic [N_IN-1:0]   edge_sel_q;
  logic [N_IN-1:0]   pend_q;
  logic [N_IN-1:0]   pend_set;
  logic [N_IN-1:0]   pend_clr;
  logic [N_IN-1:0]   stable;
  logic [N_IN-1:0]   change;
  logic [N_IN-1:0]   edge_hit;
  logic              primed;
  logic              wr_en;
  logic              rd_en;
  logic [2:0]        reg_idx;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_bus_bits;

  assign reg_idx = addr[4:2];
  assign wr_en   = en & we;
  assign rd_en   = en & ~we;

  // addr[1:0] is a byte offset inside a word and does not take part in decode.
  // wdata bits above the register widths are discarded.
  assign unused_bus_bits = ^{addr[1:0], wdata};

`ifdef GPIO_DEBOUNCE_EN
  logic [N_IN-1:0] settled;
`endif

  // One conditioner per input pin. An edge is a stable-state change toward
  // the level that EDGE_SEL selects. The new level is the inverse of the
  // current stable value.
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    gpio_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .pin     (gpio_in[i]),
`ifdef GPIO_DEBOUNCE_EN
      .settled (settled[i]),
`endif
      .stable  (stable[i]),
      .change  (change[i])
    );

    assign edge_hit[i] = change[i] & edge_match(~stable[i], edge_sel_e'(edge_sel_q[i]));
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int               PCNT_W   = $clog2(DEB_CYCLES);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(DEB_CYCLES - 1);

  logic [PCNT_W-1:0] prime_cnt;

  // Arm edge detection at one of two points, whichever comes first:
  //   - the first stable-state load after reset (that load stays silent), or
  //   - DEB_CYCLES consecutive cycles in which every input agrees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed    <= 1'b0;
      prime_cnt <= '0;
    end else if (!primed) begin
      if (|change) begin
        primed <= 1'b1;
      end else if (&settled) begin
        if (prime_cnt == PCNT_MAX) begin
          primed <= 1'b1;
        end else begin
          prime_cnt <= prime_cnt + PCNT_W'(1);
        end
      end else begin
        prime_cnt <= '0;
      end
    end
  end
`else
  logic [1:0] prime_cnt;

  // Arm edge detection on the third cycle after reset release. By then the
  // synchroniser holds the real pin levels, so those levels load silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed    <= 1'b0;
      prime_cnt <= 2'd0;
    end else if (!primed) begin
      if (prime_cnt == 2'd2) begin
        primed <= 1'b1;
      end else begin
        prime_cnt <= prime_cnt + 2'd1;
      end
    end
  end
`endif

  // An edge sets a pending bit, and writing 1 to that bit clears it.
  // When both happen in the same cycle, the set wins.
  assign pend_set = primed ? edge_hit : '0;
  assign pend_clr = (wr_en && reg_idx == GPIO_PEND) ? wdata[N_IN-1:0] : '0;

  // Control registers are written from the bus. Pending bits update every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      irq_en_q   <= '0;
      edge_sel_q <= '0;
      pend_q     <= '0;
    end else begin
      if (wr_en && reg_idx == GPIO_OUT)      out_q      <= wdata[N_OUT-1:0];
      if (wr_en && reg_idx == GPIO_IRQ_EN)   irq_en_q   <= wdata[N_IN-1:0];
      if (wr_en && reg_idx == GPIO_EDGE_SEL) edge_sel_q <= wdata[N_IN-1:0];
      pend_q <= (pend_q & ~pend_clr) | pend_set;
    end
  end

  // Read decode. Unmapped words and bits above the pin counts read as zero.
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      GPIO_OUT:      rd_mux = DATA_W'(out_q);
      GPIO_IN:       rd_mux = DATA_W'(stable);
      GPIO_IRQ_EN:   rd_mux = DATA_W'(irq_en_q);
      GPIO_EDGE_SEL: rd_mux = DATA_W'(edge_sel_q);
      GPIO_PEND:     rd_mux = DATA_W'(pend_q);
      default:       rd_mux = '0;
    endcase
  end

  // Registered read response. rdata holds its value between reads, and rvalid
  // pulses once for each read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) rdata <= rd_mux;
    end
  end

  assign gpio_out = out_q;
  assign irq      = |(pend_q & irq_en_q);

endmodule
`default_nettype wire

// File: tb/tb_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_ctrl
// Description : Directed self-checking bench for gpio_ctrl (8 out, 8 in,
//               DEB_CYCLES=16). Input-path latency follows GPIO_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_ctrl;

  localparam int N_OUT      = 8;
  localparam int N_IN       = 8;
  localparam int DEB_CYCLES = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT        = 2 + DEB_CYCLES;
  localparam bit DEB_ON     = 1'b1;
`else
  localparam int LAT        = 2;
  localparam bit DEB_ON     = 1'b0;
`endif

  localparam logic [4:0] A_OUT  = 5'h00;
  localparam logic [4:0] A_IN   = 5'h04;
  localparam logic [4:0] A_EN   = 5'h08;
  localparam logic [4:0] A_SEL  = 5'h0C;
  localparam logic [4:0] A_PEND = 5'h10;
  localparam logic [4:0] A_UNM  = 5'h14;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             we = 1'b0;
  logic [4:0]       addr = '0;
  logic [31:0]      wdata = '0;
  logic [N_IN-1:0]  gpio_in = '0;
  logic [31:0]      rdata;
  logic             rvalid;
  logic [N_OUT-1:0] gpio_out;
  logic             irq;

  int n_cmp = 0;
  int n_err = 0;

  gpio_ctrl #(
    .N_OUT      (N_OUT),
    .N_IN       (N_IN),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    addr = a; wdata = d; en = 1'b1; we = 1'b1;
    tick(1);
    en = 1'b0; we = 1'b0;
    check("write_no_rvalid", {31'd0, rvalid}, 32'd0);
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
    addr = a; en = 1'b1; we = 1'b0;
    tick(1);
    en = 1'b0;
    check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    check(tag, rdata, exp);
  endtask

  initial begin
    // ---------------- reset state ----------------
    #30;
    check("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    tick(1);
    bus_read(A_OUT, 32'd0, "rst_out");
    bus_read(A_IN, 32'd0, "rst_in");
    bus_read(A_PEND, 32'd0, "rst_pend");
    tick(1);
    check("rvalid_pulse", {31'd0, rvalid}, 32'd0);

    // ---------------- output register ----------------
    bus_write(A_OUT, 32'h0000_00A5);
    check("out_a5", {24'd0, gpio_out}, 32'h0000_00A5);
    bus_read(A_OUT, 32'h0000_00A5, "rd_out_a5");
    tick(2);
    check("rdata_hold", rdata, 32'h0000_00A5);
    check("rvalid_idle", {31'd0, rvalid}, 32'd0);

    // Back-to-back reads give one rvalid each.
    addr = A_OUT; en = 1'b1; we = 1'b0;
    tick(1);
    check("b2b_rv0", {31'd0, rvalid}, 32'd1);
    check("b2b_rd0", rdata, 32'h0000_00A5);
    addr = A_EN;
    tick(1);
    en = 1'b0;
    check("b2b_rv1", {31'd0, rvalid}, 32'd1);
    check("b2b_rd1", rdata, 32'd0);
    tick(1);
    check("b2b_rv_end", {31'd0, rvalid}, 32'd0);

    bus_write(A_OUT, 32'hFFFF_FF00);
    check("out_upper_drop", {24'd0, gpio_out}, 32'd0);
    bus_read(A_OUT, 32'd0, "rd_out_zero");

    // Unmapped words ignore writes and read as zero.
    bus_write(A_UNM, 32'hFFFF_FFFF);
    check("unm_no_out", {24'd0, gpio_out}, 32'd0);
    bus_read(A_UNM, 32'd0, "rd_unm14");
    bus_read(5'h1C, 32'd0, "rd_unm1c");

    // ---------------- debounce glitch ----------------
    bus_write(A_EN, 32'h0000_0001);
    bus_write(A_SEL, 32'h0000_0000);
    tick(20);
    gpio_in = 8'h01;
    tick(5);
    gpio_in = 8'h00;
    tick(LAT + 8);
    bus_read(A_IN, 32'd0, "glitch_in");
    bus_read(A_PEND, DEB_ON ? 32'd0 : 32'd1, "glitch_pend");
    bus_write(A_PEND, 32'h0000_0001);
    check("glitch_clr_irq", {31'd0, irq}, 32'd0);

    // ---------------- held level: exact latency + rising irq ----------------
    gpio_in = 8'h01;
    tick(LAT - 1);
    check("lat_minus1_irq", {31'd0, irq}, 32'd0);
    tick(1);
    check("lat_irq", {31'd0, irq}, 32'd1);
    bus_read(A_PEND, 32'h0000_0001, "rise_pend");
    bus_read(A_IN, 32'h0000_0001, "rise_in");
    bus_write(A_PEND, 32'h0000_0001);
    check("clr_irq", {31'd0, irq}, 32'd0);
    bus_read(A_PEND, 32'd0, "clr_pend");

    // ---------------- clear coincident with a new edge ----------------
    gpio_in = 8'h00;
    tick(LAT + 3);
    bus_read(A_PEND, 32'd0, "fall_not_sel");
    gpio_in = 8'h01;
    tick(LAT - 1);
    check("coinc_pre_irq", {31'd0, irq}, 32'd0);
    bus_write(A_PEND, 32'h0000_0001);
    check("set_wins_irq", {31'd0, irq}, 32'd1);
    bus_read(A_PEND, 32'h0000_0001, "set_wins_pend");
    bus_write(A_PEND, 32'h0000_0001);
    check("coinc_clr_irq", {31'd0, irq}, 32'd0);

    // ---------------- falling edge, masked ----------------
    bus_write(A_EN, 32'd0);
    bus_write(A_SEL, 32'h0000_0002);
    gpio_in = 8'h03;
    tick(LAT + 3);
    bus_read(A_PEND, 32'd0, "rise_ignored");
    gpio_in = 8'h01;
    tick(LAT + 3);
    bus_read(A_PEND, 32'h0000_0002, "fall_pend");
    check("masked_irq", {31'd0, irq}, 32'd0);
    bus_write(A_EN, 32'h0000_0002);
    check("unmask_irq", {31'd0, irq}, 32'd1);
    bus_read(A_EN, 32'h0000_0002, "rd_irq_en");
    bus_read(A_SEL, 32'h0000_0002, "rd_edge_sel");
    bus_write(A_PEND, 32'h0000_0002);
    check("fall_clr_irq", {31'd0, irq}, 32'd0);
    bus_write(A_SEL, 32'hFFFF_FFFF);
    bus_read(A_SEL, 32'h0000_00FF, "sel_upper_drop");

    // ---------------- reset during a read, pins high through reset ----------------
    bus_write(A_OUT, 32'h0000_003C);
    check("out_3c", {24'd0, gpio_out}, 32'h0000_003C);
    addr = A_IN; en = 1'b1; we = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", {24'd0, gpio_out}, 32'd0);
    check("async_rst_rvalid", {31'd0, rvalid}, 32'd0);
    gpio_in = 8'hFF;
    tick(1);
    check("rst_read_no_rvalid", {31'd0, rvalid}, 32'd0);
    en = 1'b0;
    #25 rst = 1'b0;
    bus_write(A_EN, 32'h0000_00FF);
    tick(LAT + 10);
    check("prime_irq", {31'd0, irq}, 32'd0);
    bus_read(A_PEND, 32'd0, "prime_pend");
    bus_read(A_IN, 32'h0000_00FF, "prime_in");
    bus_read(A_OUT, 32'd0, "prime_out");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
